// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single outstanding word requests
// to instruction memory, and drives the F/D register with redirect and stall handling.
module fetch_unit #(
  parameter int                 IMEM_AW  = 32,
  parameter logic [IMEM_AW-1:0] START_PC = 32'h8002_0000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               do_branch,
  input  logic [IMEM_AW-1:0] pc_effective,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_valid,
  output logic [IMEM_AW-1:0] pc,
  output logic [31:0]        insn_out,
  output logic [IMEM_AW-1:0] pc_out,
  output logic               insn_valid
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t             state, state_nxt;
  logic [IMEM_AW-1:0] pc_nxt, pc_out_nxt, hold_pc, hold_pc_nxt;
  logic [31:0]        insn_nxt, hold_insn, hold_insn_nxt;
  logic               vld_nxt;

  // Gated by reset so no strobe leaks out while the block is held in reset.
  assign imem_req  = (state == S_ISSUE) & ~do_branch & reset_n;
  assign imem_addr = pc;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    insn_nxt      = insn_out;
    pc_out_nxt    = pc_out;
    vld_nxt       = stall ? insn_valid : 1'b0;
    hold_insn_nxt = hold_insn;
    hold_pc_nxt   = hold_pc;

    if (do_branch) begin
      // Redirect: a stale in-flight response must still be absorbed before reissuing.
      pc_nxt        = pc_effective;
      hold_insn_nxt = '0;
      hold_pc_nxt   = '0;
      unique case (state)
        S_ISSUE: state_nxt = S_ISSUE;
        S_WAIT:  state_nxt = imem_valid ? S_ISSUE : S_DROP;
        S_HOLD:  state_nxt = S_ISSUE;
        S_DROP:  state_nxt = imem_valid ? S_ISSUE : S_DROP;
        default: state_nxt = S_ISSUE;
      endcase
    end else begin
      unique case (state)
        S_ISSUE: state_nxt = S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            pc_nxt = pc + IMEM_AW'(4);
            if (!stall) begin
              insn_nxt   = imem_rdata;
              pc_out_nxt = pc;
              vld_nxt    = 1'b1;
              state_nxt  = S_ISSUE;
            end else begin
              hold_insn_nxt = imem_rdata;
              hold_pc_nxt   = pc;
              state_nxt     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            insn_nxt   = hold_insn;
            pc_out_nxt = hold_pc;
            vld_nxt    = 1'b1;
            state_nxt  = S_ISSUE;
          end
        end
        S_DROP:  if (imem_valid) state_nxt = S_ISSUE;
        default: state_nxt = S_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_ISSUE;
      pc         <= START_PC;
      insn_out   <= '0;
      pc_out     <= '0;
      insn_valid <= 1'b0;
      hold_insn  <= '0;
      hold_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      insn_out   <= insn_nxt;
      pc_out     <= pc_out_nxt;
      insn_valid <= vld_nxt;
      hold_insn  <= hold_insn_nxt;
      hold_pc    <= hold_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a variable-latency memory model plus a
// flag-based reference of the fetch/redirect/stall rules.
module tb_fetch_unit;
  localparam logic [31:0] START = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset_n, stall, do_branch, imem_valid, imem_req, insn_valid;
  logic [31:0] pc_effective, imem_addr, imem_rdata, pc, insn_out, pc_out;

  always #5 clock = ~clock;

  fetch_unit #(.IMEM_AW(32), .START_PC(START)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .do_branch(do_branch),
    .pc_effective(pc_effective), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc(pc),
    .insn_out(insn_out), .pc_out(pc_out), .insn_valid(insn_valid)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference state: fetch PC, F/D contents, outstanding/stale request, buffered word
  logic [31:0] m_pc, m_insn, m_pcout, buf_insn, buf_pc;
  logic        m_vld, busy, stale, buf_full, exp_req;
  // memory environment
  logic        mem_busy, force_en, late_valid;
  int          mem_cnt;
  logic [31:0] mem_word, force_word;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = START; m_insn = '0; m_pcout = '0; m_vld = 1'b0;
    busy = 1'b0; stale = 1'b0; buf_full = 1'b0; buf_insn = '0; buf_pc = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_word = '0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".insn_out"}, insn_out, m_insn);
    check({tag, ".pc_out"}, pc_out, m_pcout);
    check({tag, ".insn_valid"}, {31'b0, insn_valid}, {31'b0, m_vld});
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] t, input int lat);
    logic        resp, load;
    logic [31:0] lw, lp;
    @(negedge clock);
    reset_n      = 1'b1;
    stall        = s;
    do_branch    = b;
    pc_effective = t;
    imem_valid   = late_valid || (mem_busy && mem_cnt == 1);
    imem_rdata   = late_valid ? 32'hDEAD_BEEF : mem_word;
    late_valid   = 1'b0;
    exp_req      = !busy && !buf_full && !b;
    #1;
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    check("imem_addr", imem_addr, m_pc);
    @(posedge clock);
    resp = imem_valid && busy;
    load = 1'b0; lw = '0; lp = '0;
    if (b) begin
      m_pc = t; buf_full = 1'b0;
      if (resp) busy = 1'b0;
      else if (busy) stale = 1'b1;
    end else if (exp_req) begin
      busy = 1'b1; stale = 1'b0;
    end else if (resp) begin
      busy = 1'b0;
      if (!stale) begin
        if (!s) begin load = 1'b1; lw = mem_word; lp = m_pc; end
        else begin buf_full = 1'b1; buf_insn = mem_word; buf_pc = m_pc; end
        m_pc = m_pc + 32'd4;
      end
      stale = 1'b0;
    end else if (buf_full && !s) begin
      load = 1'b1; lw = buf_insn; lp = buf_pc; buf_full = 1'b0;
    end
    if (load) begin m_insn = lw; m_pcout = lp; m_vld = 1'b1; end
    else if (!s) m_vld = 1'b0;
    // memory: retire or count down, then accept a new request
    if (imem_valid && mem_busy) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (exp_req) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
      mem_word = force_en ? force_word : word_of(m_pc);
    end
    #1;
    check_regs("step");
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++)
      if (busy || buf_full) step(1'b0, 1'b0, 32'h0, 1);
    check("drain.idle", {30'b0, busy, buf_full}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; do_branch = 1'b0; pc_effective = '0;
    imem_valid = 1'b0; imem_rdata = '0; force_en = 1'b0; force_word = '0;
    late_valid = 1'b0;
    model_reset();
    #22;
    check("rst.imem_req", {31'b0, imem_req}, 32'h0);
    check_regs("rst");

    // latency 1, no stall: sequential fetch, valid every other cycle
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1);
    check("seq.pc_out", pc_out, 32'h8002_000C);
    // latency 3
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 3);

    // stall during wait, buffered word released after stall drops
    drain();
    force_en = 1'b1; force_word = 32'h8C22_0004;
    step(1'b1, 1'b0, 32'h0, 2);
    force_en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 2);
    step(1'b0, 1'b0, 32'h0, 2);
    check("hold.insn_out", insn_out, 32'h8C22_0004);

    // redirect with a request outstanding at latency 4
    drain();
    step(1'b0, 1'b0, 32'h0, 4);
    step(1'b0, 1'b1, 32'h8002_0100, 4);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1);
    check("redir.pc_out", pc_out, 32'h8002_0104);

    // redirect and stall in the same cycle
    drain();
    step(1'b0, 1'b0, 32'h0, 2);
    step(1'b1, 1'b1, 32'h8002_0200, 2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 2);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1);

    // PC wrap at the top of the address space
    drain();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1);
    check("wrap.pc", pc, 32'h0000_0004);

    // asynchronous reset mid-wait with a late response after release
    drain();
    step(1'b0, 1'b0, 32'h0, 4);
    step(1'b0, 1'b0, 32'h0, 4);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("arst.imem_req", {31'b0, imem_req}, 32'h0);
    check_regs("arst");
    late_valid = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        s, b;
      logic [31:0] t;
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 11) == 0);
      t = $urandom;
      step(s, b, t, int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
